sdiomux_bank: RTL and testbench

- Parametrised multi-channel successor to the single-bit SDIOMUX pad cell.
- Per-channel datapaths:
  - Input: pad -> synchroniser -> glitch filter -> active-low gate, plus edge-detect pulses.
  - Output: optionally registered data/enable -> active-low gated pad.
- Sits between the SDIOMUX pad ring and fabric logic. Gives fabric clean, clock-domain-safe pad inputs and glitch-free pad outputs.

---
 rtl/sdiomux_bank.sv | 133 +++++++++++++
 tb/tb_sdiomux_bank.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/sdiomux_bank.sv
// sdiomux_bank: multi-channel pad interface bank.
// Each input channel runs pad -> synchroniser -> glitch filter -> active-low gate,
// with edge-detect pulses. Each output channel is an optionally registered,
// active-low gated pad driver.
// Optional feature macro: SDIOMUX_BANK_LOOPBACK_EN adds a LOOPBACK port that
// feeds O_PAD back into the synchronisers in place of I_PAD.
module sdiomux_bank #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter int unsigned OUT_REG       = 1
) (
  input  logic             QCK,
  input  logic             QRT,
`ifdef SDIOMUX_BANK_LOOPBACK_EN
  input  logic             LOOPBACK,
`endif
  input  logic [WIDTH-1:0] I_PAD,
  input  logic [WIDTH-1:0] I_EN,
  output logic [WIDTH-1:0] I_DAT,
  output logic [WIDTH-1:0] I_RISE,
  output logic [WIDTH-1:0] I_FALL,
  input  logic [WIDTH-1:0] O_DAT,
  input  logic [WIDTH-1:0] O_EN,
  output logic [WIDTH-1:0] O_PAD
);

  logic [WIDTH-1:0]                  sync_src;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [WIDTH-1:0]                  filt;
  logic [WIDTH-1:0]                  prev_q;

  // Synchroniser source selection
`ifdef SDIOMUX_BANK_LOOPBACK_EN
  assign sync_src = LOOPBACK ? O_PAD : I_PAD;
`else
  assign sync_src = I_PAD;
`endif

  // Multi-stage synchroniser shifting the pad level into the QCK domain
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sync_src;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  if (FILTER_CYCLES > 0) begin : g_filt
    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
    logic [WIDTH-1:0]            filt_q;
    logic [WIDTH-1:0]            filt_d;

    // Persistence counter: a new level is accepted only after FILTER_CYCLES
    // consecutive edges of disagreement; any agreement restarts the count
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_d[i] = sync[i];
            cnt_d[i]  = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end

    // Filter state registers
    always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
        cnt_q  <= '0;
        filt_q <= '0;
      end else begin
        cnt_q  <= cnt_d;
        filt_q <= filt_d;
      end
    end

    assign filt = filt_q;
  end else begin : g_nofilt
    assign filt = sync;
  end

  // Previous filtered level for edge detection
  always_ff @(posedge QCK or posedge QRT) begin
    if (QRT) begin
      prev_q <= '0;
    end else begin
      prev_q <= filt;
    end
  end

  // Active-low input gate and masked edge pulses
  assign I_DAT  = filt & ~I_EN;
  assign I_RISE = filt & ~prev_q & ~I_EN;
  assign I_FALL = ~filt & prev_q & ~I_EN;

  if (OUT_REG != 0) begin : g_oreg
    logic [WIDTH-1:0] o_dat_q;
    logic [WIDTH-1:0] o_en_q;

    // Output data/enable retiming; enable resets to the disabled (high) state
    always_ff @(posedge QCK or posedge QRT) begin
      if (QRT) begin
        o_dat_q <= '0;
        o_en_q  <= '1;
      end else begin
        o_dat_q <= O_DAT;
        o_en_q  <= O_EN;
      end
    end

    assign O_PAD = o_dat_q & ~o_en_q;
  end else begin : g_ocomb
    assign O_PAD = O_DAT & ~O_EN;
  end

endmodule

// File: tb/tb_sdiomux_bank.sv
// Directed bench for sdiomux_bank: default instance (SYNC 2, FILTER 3, OUT_REG 1)
// plus a second instance with FILTER_CYCLES=5 and a combinational output path.
`timescale 1ns/1ps
module tb_sdiomux_bank;

  logic       clk;
  logic       rst;
  logic [3:0] pad, ien, odat, oen;
  logic [3:0] idat, irise, ifall, opad;
  logic [3:0] pad5, ien5, odat5, oen5;
  logic [3:0] idat5, irise5, ifall5, opad5;
`ifdef SDIOMUX_BANK_LOOPBACK_EN
  logic       lb;
`endif

  int checks = 0;
  int errors = 0;

  sdiomux_bank dut (
    .QCK(clk), .QRT(rst),
`ifdef SDIOMUX_BANK_LOOPBACK_EN
    .LOOPBACK(lb),
`endif
    .I_PAD(pad), .I_EN(ien), .I_DAT(idat), .I_RISE(irise), .I_FALL(ifall),
    .O_DAT(odat), .O_EN(oen), .O_PAD(opad)
  );

  sdiomux_bank #(.FILTER_CYCLES(5), .OUT_REG(0)) dut5 (
    .QCK(clk), .QRT(rst),
`ifdef SDIOMUX_BANK_LOOPBACK_EN
    .LOOPBACK(1'b0),
`endif
    .I_PAD(pad5), .I_EN(ien5), .I_DAT(idat5), .I_RISE(irise5), .I_FALL(ifall5),
    .O_DAT(odat5), .O_EN(oen5), .O_PAD(opad5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pad = 4'hF; odat = 4'hF; oen = 4'h0; ien = 4'h0;
    pad5 = 4'h0; ien5 = 4'h0; odat5 = 4'h0; oen5 = 4'hF;
`ifdef SDIOMUX_BANK_LOOPBACK_EN
    lb = 1'b0;
`endif
    #1;
    checks++; if (idat !== 4'h0) begin errors++; $display("FAIL reset_idat got %h exp 0", idat); end
    checks++; if (irise !== 4'h0 || ifall !== 4'h0) begin errors++; $display("FAIL reset_edges got %h/%h exp 0/0", irise, ifall); end
    checks++; if (opad !== 4'h0) begin errors++; $display("FAIL reset_opad got %h exp 0", opad); end
    step(); step();
    checks++; if (idat !== 4'h0 || opad !== 4'h0) begin errors++; $display("FAIL reset_hold got %h/%h exp 0/0", idat, opad); end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (idat !== ((k == 5) ? 4'hF : 4'h0) || irise !== ((k == 5) ? 4'hF : 4'h0)) begin
        errors++; $display("FAIL release_edge%0d idat %h rise %h", k, idat, irise);
      end
      if (k == 1) begin
        checks++; if (opad !== 4'hF) begin errors++; $display("FAIL release_opad got %h exp f", opad); end
      end
    end
    step();
    checks++; if (idat !== 4'hF || irise !== 4'h0) begin errors++; $display("FAIL rise_single idat %h rise %h exp f/0", idat, irise); end
  endtask

  task automatic test_glitch();
    pad5 = 4'b0010;
    for (int k = 1; k <= 4; k++) step();
    pad5 = 4'h0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (idat5 !== 4'h0 || irise5 !== 4'h0) begin errors++; $display("FAIL glitch_reject%0d idat %h rise %h", k, idat5, irise5); end
    end
    pad5 = 4'b0010;
    for (int k = 1; k <= 6; k++) step();
    checks++; if (idat5 !== 4'h0) begin errors++; $display("FAIL pulse_early got %h exp 0", idat5); end
    pad5 = 4'h0;
    step();
    checks++; if (idat5 !== 4'b0010 || irise5 !== 4'b0010) begin errors++; $display("FAIL pulse_accept idat %h rise %h exp 2/2", idat5, irise5); end
    for (int k = 8; k <= 12; k++) begin
      step();
      checks++;
      if (idat5 !== 4'b0010 || ifall5 !== 4'h0 || irise5 !== 4'h0) begin
        errors++; $display("FAIL pulse_hold%0d idat %h fall %h rise %h", k, idat5, ifall5, irise5);
      end
    end
    step();
    checks++; if (idat5 !== 4'h0 || ifall5 !== 4'b0010) begin errors++; $display("FAIL pulse_fall idat %h fall %h exp 0/2", idat5, ifall5); end
    step();
    checks++; if (ifall5 !== 4'h0) begin errors++; $display("FAIL fall_single got %h exp 0", ifall5); end
  endtask

  task automatic test_enable();
    ien = 4'b0100;
    #1;
    checks++; if (idat !== 4'b1011 || irise !== 4'h0 || ifall !== 4'h0) begin
      errors++; $display("FAIL en_off idat %h rise %h fall %h exp b/0/0", idat, irise, ifall);
    end
    step();
    checks++; if (idat !== 4'b1011 || ifall !== 4'h0) begin errors++; $display("FAIL en_off_hold idat %h fall %h", idat, ifall); end
    ien = 4'h0;
    #1;
    checks++; if (idat !== 4'hF || irise !== 4'h0 || ifall !== 4'h0) begin
      errors++; $display("FAIL en_on idat %h rise %h fall %h exp f/0/0", idat, irise, ifall);
    end
  endtask

  task automatic test_output();
    oen = 4'b1110; odat = 4'b0101;
    oen5 = 4'b1110; odat5 = 4'b0101;
    #1;
    checks++; if (opad !== 4'hF) begin errors++; $display("FAIL oreg_latency got %h exp f", opad); end
    checks++; if (opad5 !== 4'b0001) begin errors++; $display("FAIL ocomb got %h exp 1", opad5); end
    step();
    checks++; if (opad !== 4'b0001) begin errors++; $display("FAIL oreg got %h exp 1", opad); end
    odat5 = 4'b1111; oen5 = 4'b0011;
    #1;
    checks++; if (opad5 !== 4'b1100) begin errors++; $display("FAIL ocomb2 got %h exp c", opad5); end
  endtask

  task automatic test_reset_mid();
    pad = 4'h7;
    for (int k = 1; k <= 5; k++) step();
    checks++; if (idat !== 4'h7 || ifall !== 4'h8) begin errors++; $display("FAIL ch3_fall idat %h fall %h exp 7/8", idat, ifall); end
    pad = 4'hF;
    for (int k = 1; k <= 4; k++) step();
    checks++; if (idat !== 4'h7) begin errors++; $display("FAIL mid_pending got %h exp 7", idat); end
    rst = 1'b1;
    #1;
    checks++; if (idat !== 4'h0 || ifall !== 4'h0 || irise !== 4'h0) begin
      errors++; $display("FAIL mid_reset idat %h fall %h rise %h exp 0/0/0", idat, ifall, irise);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (idat !== ((k == 5) ? 4'hF : 4'h0) || irise !== ((k == 5) ? 4'hF : 4'h0) || ifall !== 4'h0) begin
        errors++; $display("FAIL mid_release%0d idat %h rise %h fall %h", k, idat, irise, ifall);
      end
    end
  endtask

`ifdef SDIOMUX_BANK_LOOPBACK_EN
  task automatic test_loopback();
    rst = 1'b1; lb = 1'b1; pad = 4'h0; oen = 4'h0; odat = 4'hA; ien = 4'h0;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (idat !== ((k == 6) ? 4'hA : 4'h0) || irise !== ((k == 6) ? 4'hA : 4'h0)) begin
        errors++; $display("FAIL loopback%0d idat %h rise %h", k, idat, irise);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_glitch();
    test_enable();
    test_output();
    test_reset_mid();
`ifdef SDIOMUX_BANK_LOOPBACK_EN
    test_loopback();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
